rx_sync_aligner: RTL and testbench
==================================

RX_SYNC_ALIGNER -- requirements
Module: rx_sync_aligner

Interface
REQ-001 Parameter SLIP_TIMEOUT, default 20: number of consecutive non-comma code groups in LOSS_OF_SYNC that triggers a bit slip.
REQ-002 Parameter SLIP_HOLD, default 4: number of cycles after a slip pulse during which input is ignored.
REQ-003 i_CoreClk  in  1  recovered core clock; one code group per cycle.
REQ-004 i_XcverDigitalRst  in  1  reset; asynchronous, active-high.
REQ-005 i_SignalDetect  in  1  receiver signal present.
REQ-006 i8_RxCodeGroup  in  8  decoded code group.
REQ-007 i_RxCodeCtrl  in  1  code group is a K character.
REQ-008 i_RxCodeInvalid  in  1  code or disparity error.
REQ-009 o_RxBitSlip  out  1  single-cycle slip request to the deserializer.
REQ-010 o_SyncStatus  out  1  1 = link synchronized.
REQ-011 o_RxEven  out  1  even/odd code-group phase of the current output.
REQ-012 o8_RxCodeGroup, o_RxCodeCtrl, o_RxCodeInvalid  out  8/1/1  input code group registered by one cycle.
REQ-013 o4_SlipCnt  out  4  slips issued; counts 0..9, then wraps to 0.

Function
REQ-014 Comma: i_RxCodeCtrl=1 and i8_RxCodeGroup=8'hBC (K28.5) with i_RxCodeInvalid=0.
REQ-015 Data group (D): i_RxCodeCtrl=0 and i_RxCodeInvalid=0.
REQ-016 cgbad: i_RxCodeInvalid=1, or comma while the phase is even. cggood: not cgbad.
REQ-017 Data outputs: registered copies of the inputs, latency 1 cycle. o_RxEven and o_SyncStatus are aligned to the same output cycle.
REQ-018 Phase: toggles every cycle. It is forced to even on the cycle a comma is accepted in any LOSS_OF_SYNC or ACQUIRE_SYNC_n transition.
REQ-019 Acquisition states: LOSS_OF_SYNC, COMMA_DETECT_1..3, ACQUIRE_SYNC_1..2.
REQ-020 LOSS_OF_SYNC -> COMMA_DETECT_1 on comma while i_SignalDetect=1.
REQ-021 COMMA_DETECT_n -> ACQUIRE_SYNC_n on D (COMMA_DETECT_3 -> SYNC_ACQUIRED_1); any other group -> LOSS_OF_SYNC.
REQ-022 ACQUIRE_SYNC_n -> COMMA_DETECT_n+1 on comma in the odd phase; -> LOSS_OF_SYNC on cgbad; otherwise stay.
REQ-023 Tracking states: SYNC_ACQUIRED_1, 2, 2A, 3, 3A, 4, 4A. o_SyncStatus=1 in all of them, 0 elsewhere.
REQ-024 SYNC_ACQUIRED_1: stay on cggood; cgbad -> SYNC_ACQUIRED_2.
REQ-025 SYNC_ACQUIRED_k (k=2..4): cggood -> kA with good_cgs=0; cgbad -> k+1 (k=4 -> LOSS_OF_SYNC).
REQ-026 SYNC_ACQUIRED_kA: cggood increments good_cgs. On the 4th consecutive cggood -> k-1 (2A -> SYNC_ACQUIRED_1). cgbad -> k+1 (4A -> LOSS_OF_SYNC).
REQ-027 i_SignalDetect=0 forces LOSS_OF_SYNC on the next edge from any state, overriding all other transitions.
REQ-028 Slip timer: runs only in LOSS_OF_SYNC outside hold. Increments per non-comma group; clears on comma or on leaving LOSS_OF_SYNC.
REQ-029 When the timer reaches SLIP_TIMEOUT: o_RxBitSlip=1 for exactly one cycle, o4_SlipCnt advances, timer clears, and a hold of SLIP_HOLD cycles begins.
REQ-030 During hold: commas are ignored, no state transition occurs, and no further slip is issued.
REQ-031 i_SignalDetect=0 suppresses slipping and clears the timer.
REQ-032 o_RxBitSlip is never asserted in consecutive cycles, nor outside LOSS_OF_SYNC.

Reset
REQ-033 While i_XcverDigitalRst=1, asynchronously: state=LOSS_OF_SYNC, timers=0, o4_SlipCnt=0, and all outputs=0.
REQ-034 Reset asserted mid-slip or mid-hold aborts the operation. After release, the block resumes from a clean LOSS_OF_SYNC with the timer at 0.

Verification
REQ-035 Stream K28.5,D5.6 repeated with i_SignalDetect=1 -> o_SyncStatus rises after 3 accepted commas (COMMA_DETECT_3 + D); o_RxEven=1 on every output K28.5.
REQ-036 Only D0.0 with i_SignalDetect=1 -> o_RxBitSlip pulses every SLIP_TIMEOUT+SLIP_HOLD (24) cycles; o4_SlipCnt reads 0,1..9,0.
REQ-037 Synced link plus one invalid group, then 4 good groups -> SYNC_ACQUIRED_2 -> 2A -> SYNC_ACQUIRED_1; o_SyncStatus stays 1.
REQ-038 Synced link plus 4 invalid groups spaced 2 good groups apart -> LOSS_OF_SYNC; o_SyncStatus=0 one cycle after the 4th bad group.
REQ-039 Comma in the even phase while SYNC_ACQUIRED_1 -> counted as cgbad (-> SYNC_ACQUIRED_2).
REQ-040 i_SignalDetect dropped while synced, and separately reset pulsed during hold -> o_SyncStatus=0 next edge; no o_RxBitSlip during the pulse or hold; counters=0.

Source files
------------

// File: rtl/rx_sync_aligner.sv
// Code-group synchronization and comma alignment for a recovered 8b/10b receive stream.
// Tracks link sync state and requests deserializer bit slips while no comma is found.
module rx_sync_aligner #(
    parameter int unsigned SLIP_TIMEOUT = 20,
    parameter int unsigned SLIP_HOLD    = 4
) (
    input  logic       i_CoreClk,
    input  logic       i_XcverDigitalRst,
    input  logic       i_SignalDetect,
    input  logic [7:0] i8_RxCodeGroup,
    input  logic       i_RxCodeCtrl,
    input  logic       i_RxCodeInvalid,
    output logic       o_RxBitSlip,
    output logic       o_SyncStatus,
    output logic       o_RxEven,
    output logic [7:0] o8_RxCodeGroup,
    output logic       o_RxCodeCtrl,
    output logic       o_RxCodeInvalid,
    output logic [3:0] o4_SlipCnt
);

    localparam int unsigned TimerW = $clog2(SLIP_TIMEOUT + 2);
    localparam int unsigned HoldW  = $clog2(SLIP_HOLD + 2);

    typedef enum logic [3:0] {
        LossOfSync, CommaDet1, CommaDet2, CommaDet3, AcqSync1, AcqSync2,
        SyncAcq1, SyncAcq2, SyncAcq2A, SyncAcq3, SyncAcq3A, SyncAcq4, SyncAcq4A
    } stateT;

    stateT             stateQ, stateD;
    logic              evenQ, evenD;
    logic [1:0]        goodQ, goodD;
    logic [TimerW-1:0] timerQ, timerD;
    logic [HoldW-1:0]  holdQ, holdD;
    logic              slipQ, slipD;
    logic [3:0]        slipCntQ, slipCntD;

    logic isComma, isData, cgBad, inHold;

    assign isComma = i_RxCodeCtrl && (i8_RxCodeGroup == 8'hBC) && !i_RxCodeInvalid;
    assign isData  = !i_RxCodeCtrl && !i_RxCodeInvalid;
    // evenQ is the phase of the previous group, so a comma following an even group is misaligned.
    assign cgBad   = i_RxCodeInvalid || (isComma && evenQ);
    assign inHold  = (holdQ != '0);

    always_comb begin
        stateD   = stateQ;
        evenD    = ~evenQ;
        goodD    = goodQ;
        timerD   = timerQ;
        holdD    = inHold ? holdQ - 1'b1 : holdQ;
        slipD    = 1'b0;
        slipCntD = slipCntQ;

        case (stateQ)
            LossOfSync: begin
                if (!inHold && i_SignalDetect) begin
                    if (isComma) begin
                        stateD = CommaDet1;
                        evenD  = 1'b1;
                        timerD = '0;
                    end else if (timerQ == TimerW'(SLIP_TIMEOUT - 1)) begin
                        slipD    = 1'b1;
                        timerD   = '0;
                        holdD    = HoldW'(SLIP_HOLD);
                        slipCntD = (slipCntQ == 4'd9) ? 4'd0 : slipCntQ + 4'd1;
                    end else begin
                        timerD = timerQ + 1'b1;
                    end
                end
            end
            CommaDet1: stateD = isData ? AcqSync1 : LossOfSync;
            CommaDet2: stateD = isData ? AcqSync2 : LossOfSync;
            CommaDet3: stateD = isData ? SyncAcq1 : LossOfSync;
            AcqSync1, AcqSync2: begin
                if (isComma && !evenQ) begin
                    stateD = (stateQ == AcqSync1) ? CommaDet2 : CommaDet3;
                    evenD  = 1'b1;
                end else if (cgBad) begin
                    stateD = LossOfSync;
                end
            end
            SyncAcq1: if (cgBad) stateD = SyncAcq2;
            SyncAcq2: begin
                stateD = cgBad ? SyncAcq3 : SyncAcq2A;
                goodD  = 2'd0;
            end
            SyncAcq3: begin
                stateD = cgBad ? SyncAcq4 : SyncAcq3A;
                goodD  = 2'd0;
            end
            SyncAcq4: begin
                stateD = cgBad ? LossOfSync : SyncAcq4A;
                goodD  = 2'd0;
            end
            // The good group that entered the A state counts as the first of four.
            SyncAcq2A, SyncAcq3A, SyncAcq4A: begin
                if (cgBad) begin
                    stateD = (stateQ == SyncAcq2A) ? SyncAcq3 :
                             (stateQ == SyncAcq3A) ? SyncAcq4 : LossOfSync;
                end else if (goodQ == 2'd2) begin
                    stateD = (stateQ == SyncAcq2A) ? SyncAcq1 :
                             (stateQ == SyncAcq3A) ? SyncAcq2 : SyncAcq3;
                end else begin
                    goodD = goodQ + 2'd1;
                end
            end
            default: stateD = LossOfSync;
        endcase

        if (!i_SignalDetect) begin
            stateD   = LossOfSync;
            slipD    = 1'b0;
            slipCntD = slipCntQ;
        end
        if (!i_SignalDetect || stateD != LossOfSync) begin
            timerD = '0;
        end
    end

    always_ff @(posedge i_CoreClk or posedge i_XcverDigitalRst) begin
        if (i_XcverDigitalRst) begin
            stateQ          <= LossOfSync;
            evenQ           <= 1'b0;
            goodQ           <= 2'd0;
            timerQ          <= '0;
            holdQ           <= '0;
            slipQ           <= 1'b0;
            slipCntQ        <= 4'd0;
            o8_RxCodeGroup  <= 8'h00;
            o_RxCodeCtrl    <= 1'b0;
            o_RxCodeInvalid <= 1'b0;
        end else begin
            stateQ          <= stateD;
            evenQ           <= evenD;
            goodQ           <= goodD;
            timerQ          <= timerD;
            holdQ           <= holdD;
            slipQ           <= slipD;
            slipCntQ        <= slipCntD;
            o8_RxCodeGroup  <= i8_RxCodeGroup;
            o_RxCodeCtrl    <= i_RxCodeCtrl;
            o_RxCodeInvalid <= i_RxCodeInvalid;
        end
    end

    assign o_RxBitSlip  = slipQ;
    assign o_RxEven     = evenQ;
    assign o4_SlipCnt   = slipCntQ;
    assign o_SyncStatus = stateQ inside {SyncAcq1, SyncAcq2, SyncAcq2A, SyncAcq3, SyncAcq3A,
                                         SyncAcq4, SyncAcq4A};

endmodule

// File: tb/tb_rx_sync_aligner.sv
// Bench for rx_sync_aligner: directed scenarios plus random streams against a behavioural
// model that tracks sync as (accepted commas, error level, good run) rather than named states.
module tb_rx_sync_aligner;

    localparam int SlipTimeout = 20;
    localparam int SlipHold    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sigDet = 1'b0;
    logic [7:0] rxCg = 8'h00;
    logic       rxCtrl = 1'b0;
    logic       rxInv = 1'b0;
    logic       bitSlip, syncStatus, rxEven, outCtrl, outInv;
    logic [7:0] outCg;
    logic [3:0] slipCnt;

    rx_sync_aligner #(
        .SLIP_TIMEOUT(SlipTimeout),
        .SLIP_HOLD   (SlipHold)
    ) dut (
        .i_CoreClk        (clk),
        .i_XcverDigitalRst(rst),
        .i_SignalDetect   (sigDet),
        .i8_RxCodeGroup   (rxCg),
        .i_RxCodeCtrl     (rxCtrl),
        .i_RxCodeInvalid  (rxInv),
        .o_RxBitSlip      (bitSlip),
        .o_SyncStatus     (syncStatus),
        .o_RxEven         (rxEven),
        .o8_RxCodeGroup   (outCg),
        .o_RxCodeCtrl     (outCtrl),
        .o_RxCodeInvalid  (outInv),
        .o4_SlipCnt       (slipCnt)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    // Model: mode 0 = lost, 1 = acquiring, 2 = synced.
    int         mMode, mCommas, mLevel, mRun, mTimer, mHold, mCnt;
    bit         mNeedData, mEven, mSlip;
    logic [9:0] mData;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        mMode = 0; mCommas = 0; mLevel = 0; mRun = 0; mTimer = 0; mHold = 0; mCnt = 0;
        mNeedData = 0; mEven = 0; mSlip = 0; mData = '0;
    endtask

    task automatic modelStep(input bit sd, input logic [7:0] cg, input bit ctrl, input bit inv);
        bit comma, data, bad, nextEven;
        comma    = ctrl && (cg == 8'hBC) && !inv;
        data     = !ctrl && !inv;
        bad      = inv || (comma && mEven);
        nextEven = !mEven;
        mSlip    = 0;
        case (mMode)
            0: begin
                if (mHold > 0) mHold--;
                else if (sd) begin
                    if (comma) begin
                        mMode = 1; mCommas = 1; mNeedData = 1; nextEven = 1; mTimer = 0;
                    end else begin
                        mTimer++;
                        if (mTimer == SlipTimeout) begin
                            mSlip = 1; mTimer = 0; mHold = SlipHold; mCnt = (mCnt + 1) % 10;
                        end
                    end
                end
            end
            1: begin
                if (mNeedData) begin
                    if (!data) mMode = 0;
                    else begin
                        mNeedData = 0;
                        if (mCommas == 3) begin mMode = 2; mLevel = 1; mRun = 0; end
                    end
                end else if (comma && !mEven) begin
                    mCommas++; mNeedData = 1; nextEven = 1;
                end else if (bad) mMode = 0;
            end
            default: begin
                if (bad) begin
                    mLevel++; mRun = 0;
                    if (mLevel > 4) mMode = 0;
                end else if (mLevel > 1) begin
                    mRun++;
                    if (mRun == 4) begin mLevel--; mRun = 0; end
                end
            end
        endcase
        if (!sd) begin mMode = 0; mTimer = 0; end
        mEven = nextEven;
        mData = {cg, ctrl, inv};
    endtask

    task automatic compareAll();
        checkEq("sync", syncStatus, (mMode == 2));
        checkEq("even", rxEven, mEven);
        checkEq("slip", bitSlip, mSlip);
        checkEq("slipCnt", slipCnt, mCnt);
        checkEq("data", {outCg, outCtrl, outInv}, mData);
    endtask

    task automatic step(input bit sd, input logic [7:0] cg, input bit ctrl, input bit inv);
        sigDet = sd; rxCg = cg; rxCtrl = ctrl; rxInv = inv;
        @(posedge clk);
        modelStep(sd, cg, ctrl, inv);
        #1;
        compareAll();
    endtask

    task automatic doReset();
        #3; rst = 1'b1; #1;
        checkEq("rstSync", syncStatus, 0);
        checkEq("rstSlip", bitSlip, 0);
        checkEq("rstCnt", slipCnt, 0);
        checkEq("rstEven", rxEven, 0);
        checkEq("rstData", {outCg, outCtrl, outInv}, 0);
        modelReset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic syncUp();
        for (int i = 0; i < 8; i++) begin
            step(1, 8'hBC, 1, 0);
            step(1, 8'hC5, 0, 0);
        end
        checkEq("acquired", syncStatus, 1);
    endtask

    int  lastSlip, nSlips, kind, r;
    bit  kd, found;

    initial begin
        modelReset();
        doReset();

        // Comma alignment: K28.5/D5.6 stream
        syncUp();

        // One invalid group then four good groups returns to the error-free level
        step(1, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 8'hC5, 0, 0);
        checkEq("recover", syncStatus, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h00, 0, 1);
            step(1, 8'hC5, 0, 0);
        end
        checkEq("recoveredLevel1", syncStatus, 1);

        // Four bad groups spaced by two good groups lose sync
        doReset();
        syncUp();
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h00, 0, 1);
            if (i < 3) begin
                step(1, 8'hC5, 0, 0);
                step(1, 8'hC5, 0, 0);
            end
        end
        checkEq("lossAfter4Bad", syncStatus, 0);

        // Comma in the even phase counts as bad
        doReset();
        syncUp();
        step(1, 8'hBC, 1, 0);
        step(1, 8'hBC, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h00, 0, 1);
            if (i < 2) step(1, 8'hC5, 0, 0);
        end
        checkEq("evenCommaBad", syncStatus, 0);

        // Signal detect drop while synced
        syncUp();
        step(0, 8'hC5, 0, 0);
        checkEq("sdDropSync", syncStatus, 0);

        // Slip cadence on data-only stream
        doReset();
        lastSlip = -1; nSlips = 0;
        for (int i = 1; i <= 300; i++) begin
            step(1, 8'h00, 0, 0);
            if (bitSlip) begin
                if (lastSlip >= 0) checkEq("slipPeriod", i - lastSlip, SlipTimeout + SlipHold);
                lastSlip = i;
                nSlips++;
            end
        end
        checkEq("slipTotal", nSlips, 12);
        checkEq("slipCntWrap", slipCnt, 2);

        // Reset during hold aborts it and restarts the timer cleanly
        doReset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1, 8'h00, 0, 0);
            found = bitSlip;
        end
        checkEq("slipSeen", found, 1);
        step(1, 8'hBC, 1, 0);
        step(1, 8'h00, 0, 0);
        doReset();
        for (int i = 0; i < 30; i++) step(1, 8'h00, 0, 0);

        // Random segments
        for (int seg = 0; seg < 12; seg++) begin
            kind = $urandom_range(0, 2);
            kd = 1;
            for (int i = 0; i < 150; i++) begin
                r = $urandom_range(0, 99);
                case (kind)
                    0: begin
                        if (kd) step($urandom_range(0, 199) != 0, 8'hBC, 1, r < 3);
                        else    step($urandom_range(0, 199) != 0, 8'hC5, 0, r < 3);
                        if (!(r >= 3 && r < 5)) kd = !kd;
                    end
                    1: step($urandom_range(0, 199) != 0, 8'($urandom), 0, r < 1);
                    default: step($urandom_range(0, 49) != 0,
                                  ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom),
                                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
                endcase
            end
            if (seg == 6) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
